fifo_uart_tx: RTL

Drains bytes from the output FIFO that the case-conversion stage writes into, and serialises each byte onto a UART TX line (8N1, LSB first). It is the reading end of the FIFO write interface (`o_write_enable`/`o_data`) driven by the converter, and closes the RX → convert → TX loopback path. One byte is read from the FIFO only when the transmitter is idle, so the FIFO absorbs all backpressure.

---
 rtl/fifo_uart_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter: pops one byte per frame while idle and
// shifts it out LSB first on a registered, idle-high TX line.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 208
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Data_Empty,
  input  logic [7:0] i_data,
  output logic       o_read_enable,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end = (baud == CNT_MAX);

  // o_tx is always loaded with the level of the bit about to start, so it
  // never depends combinationally on any input.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state         <= IDLE;
      baud          <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      o_tx          <= 1'b1;
      o_read_enable <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_read_enable <= 1'b0;
      o_done        <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (!i_Data_Empty) begin
            state         <= READ;
            o_read_enable <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        READ: begin
          state <= LOAD;
        end
        LOAD: begin
          shift   <= i_data;
          bit_idx <= '0;
          baud    <= '0;
          o_tx    <= 1'b0;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            baud  <= '0;
            o_tx  <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud    <= '0;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              o_tx <= shift[1];
            end
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud   <= '0;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            baud <= baud + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
